// File: rtl/operand_fetch_if.sv
// Handshake and bus bundle between the operand fetch sequencer and its host/consumers.
// master = the sequencer (drives reads and beat sideband), slave = host and downstream.
interface operand_fetch_if;
  logic        start;
  logic        is_int4;
  logic        hold;
  logic        rd_en;
  logic [6:0]  addr_a;
  logic [10:0] addr_b;
  logic        beat_valid;
  logic        beat_first;
  logic        beat_last;
  logic [1:0]  beat_tile;
  logic [5:0]  beat_col;
  logic        busy;
  logic        done;

  modport master (
    input  start, is_int4, hold,
    output rd_en, addr_a, addr_b, beat_valid, beat_first, beat_last,
           beat_tile, beat_col, busy, done
  );

  modport slave (
    output start, is_int4, hold,
    input  rd_en, addr_a, addr_b, beat_valid, beat_first, beat_last,
           beat_tile, beat_col, busy, done
  );
endinterface

// File: rtl/operand_fetch_sequencer.sv
// Read-side sequencer for the A/B operand SRAMs: walks k, then B column, then A row-tile,
// and delivers a beat-aligned sideband SRAM_LAT cycles after each read.
//
// state | meaning
// IDLE  | waiting for start; accepting start also issues the first read
// ISSUE | one read per cycle while hold=0
// DRAIN | all reads issued, waiting for the final beat to emerge
// DONE  | one-cycle done pulse, busy low
module operand_fetch_sequencer #(
  parameter int SRAM_LAT = 1,
  parameter int N_TILES  = 4,
  parameter int N_COLS   = 64,
  parameter int K_STRIDE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  operand_fetch_if.master  bus
);

  localparam int KW = (K_STRIDE > 1) ? $clog2(K_STRIDE) : 1;
  localparam logic [1:0]    TILE_LAST = 2'(N_TILES - 1);
  localparam logic [5:0]    COL_LAST  = 6'(N_COLS - 1);
  localparam logic [KW-1:0] K_MAX8    = KW'(K_STRIDE - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic       valid;
    logic       first;
    logic       last;
    logic [1:0] tile;
    logic [5:0] col;
  } beat_t;

  state_t         state_q;
  logic [KW-1:0]  k_q, kmax_q;
  logic [5:0]     col_q;
  logic [1:0]     tile_q;
  logic [6:0]     addr_a_q;
  logic [10:0]    addr_b_q;
  logic           busy_q, done_q;
  beat_t          issue_q;
  beat_t          pipe_q [SRAM_LAT];

  logic [KW-1:0]  k_cur, kmax_cur, k_d;
  logic [5:0]     col_cur, col_d;
  logic [1:0]     tile_cur, tile_d;
  logic [6:0]     addr_a_d;
  logic [10:0]    addr_b_d;
  logic           do_issue, k_last, col_last, tile_last, is_final;
  beat_t          beat_d, beat_out;
  logic           last_emerged;

  // In IDLE the counters are viewed as cleared so the accepting edge issues read 0.
  always_comb begin
    k_cur    = k_q;
    kmax_cur = kmax_q;
    col_cur  = col_q;
    tile_cur = tile_q;
    do_issue = 1'b0;
    case (state_q)
      S_IDLE: begin
        k_cur    = '0;
        col_cur  = '0;
        tile_cur = '0;
        kmax_cur = bus.is_int4 ? '0 : K_MAX8;
        do_issue = bus.start;
      end
      S_ISSUE: do_issue = !bus.hold;
      default: ;
    endcase

    k_last    = (k_cur == kmax_cur);
    col_last  = (col_cur == COL_LAST);
    tile_last = (tile_cur == TILE_LAST);
    is_final  = k_last && col_last && tile_last;

    k_d    = k_last ? '0 : k_cur + 1'b1;
    col_d  = k_last ? (col_last ? '0 : col_cur + 6'd1) : col_cur;
    tile_d = (k_last && col_last) ? tile_cur + 2'd1 : tile_cur;

    addr_a_d = 7'(tile_cur) * 7'(K_STRIDE) + 7'(k_cur);
    addr_b_d = 11'(col_cur) * 11'(K_STRIDE) + 11'(k_cur);

    beat_d = '0;
    if (do_issue) begin
      beat_d.valid = 1'b1;
      beat_d.first = (k_cur == '0);
      beat_d.last  = k_last;
      beat_d.tile  = tile_cur;
      beat_d.col   = col_cur;
    end
  end

  assign beat_out     = pipe_q[SRAM_LAT-1];
  assign last_emerged = beat_out.valid && beat_out.last &&
                        (beat_out.tile == TILE_LAST) && (beat_out.col == COL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      kmax_q   <= '0;
      col_q    <= '0;
      tile_q   <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      issue_q  <= '0;
      for (int i = 0; i < SRAM_LAT; i++) pipe_q[i] <= '0;
    end else begin
      // The pipe shifts unconditionally so hold never stalls reads already in flight.
      issue_q   <= beat_d;
      pipe_q[0] <= issue_q;
      for (int i = 1; i < SRAM_LAT; i++) pipe_q[i] <= pipe_q[i-1];

      if (do_issue) begin
        addr_a_q <= addr_a_d;
        addr_b_q <= addr_b_d;
        k_q      <= k_d;
        col_q    <= col_d;
        tile_q   <= tile_d;
      end

      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q <= is_final ? S_DRAIN : S_ISSUE;
            kmax_q  <= kmax_cur;
            busy_q  <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (do_issue && is_final) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (last_emerged) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_en      = issue_q.valid;
  assign bus.addr_a     = addr_a_q;
  assign bus.addr_b     = addr_b_q;
  assign bus.beat_valid = beat_out.valid;
  assign bus.beat_first = beat_out.first;
  assign bus.beat_last  = beat_out.last;
  assign bus.beat_tile  = beat_out.tile;
  assign bus.beat_col   = beat_out.col;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_operand_fetch_sequencer.sv
// Bench for operand_fetch_sequencer: a SRAM_LAT=1 and a SRAM_LAT=3 instance driven in lockstep.
module tb_operand_fetch_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_fetch_if if0();
  operand_fetch_if if1();

  operand_fetch_sequencer #(.SRAM_LAT(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));
  operand_fetch_sequencer #(.SRAM_LAT(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic i4, input logic hd);
    if0.start = st; if0.is_int4 = i4; if0.hold = hd;
    if1.start = st; if1.is_int4 = i4; if1.hold = hd;
  endtask

  // Reference model: beat n of a run with k-step count run_k.
  int run_k = 2;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [17:0] exp_addr(input int n);
    int k, col, tile;
    k = n % run_k; col = (n / run_k) % 64; tile = n / (run_k * 64);
    return {7'(tile * 2 + k), 11'(col * 2 + k)};
  endfunction

  function automatic logic [9:0] exp_side(input int n);
    int k, col, tile;
    k = n % run_k; col = (n / run_k) % 64; tile = n / (run_k * 64);
    return {k == 0, k == run_k - 1, 2'(tile), 6'(col)};
  endfunction

  int iss_n [2];
  int beat_n [2];
  int stq0 [$];
  int stq1 [$];
  bit mon_en = 1'b0;

  task automatic mon(input int d, input int lat, input logic rd, input logic [6:0] a,
                     input logic [10:0] b, input logic bv, input logic bf, input logic bl,
                     input logic [1:0] bt, input logic [5:0] bc);
    int st;
    if (bv) begin
      if ((d == 0 && stq0.size() == 0) || (d == 1 && stq1.size() == 0)) begin
        chk($sformatf("dut%0d beat_without_read", d), 1, 0);
      end else begin
        st = (d == 0) ? stq0.pop_front() : stq1.pop_front();
        chk($sformatf("dut%0d beat_latency #%0d", d, beat_n[d]), cyc - st, lat);
      end
      chk($sformatf("dut%0d sideband #%0d", d, beat_n[d]), {bf, bl, bt, bc}, exp_side(beat_n[d]));
      beat_n[d]++;
    end
    if (rd) begin
      chk($sformatf("dut%0d addr #%0d", d, iss_n[d]), {a, b}, exp_addr(iss_n[d]));
      if (d == 0) stq0.push_back(cyc); else stq1.push_back(cyc);
      iss_n[d]++;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      mon(0, 1, if0.rd_en, if0.addr_a, if0.addr_b, if0.beat_valid, if0.beat_first,
          if0.beat_last, if0.beat_tile, if0.beat_col);
      mon(1, 3, if1.rd_en, if1.addr_a, if1.addr_b, if1.beat_valid, if1.beat_first,
          if1.beat_last, if1.beat_tile, if1.beat_col);
    end
  end

  task automatic clear_model(input int k);
    run_k = k;
    iss_n[0] = 0; iss_n[1] = 0; beat_n[0] = 0; beat_n[1] = 0;
    stq0.delete(); stq1.delete();
  endtask

  function automatic logic [35:0] outs0();
    return {if0.rd_en, if0.addr_a, if0.addr_b, if0.beat_valid, if0.beat_first, if0.beat_last,
            if0.beat_tile, if0.beat_col, if0.busy, if0.done};
  endfunction

  function automatic logic [35:0] outs1();
    return {if1.rd_en, if1.addr_a, if1.addr_b, if1.beat_valid, if1.beat_first, if1.beat_last,
            if1.beat_tile, if1.beat_col, if1.busy, if1.done};
  endfunction

  typedef struct {
    bit          is_int4;
    int          hold_at;     // issued-read count at which hold rises
    int          hold_len;
    int          start_at;    // issued-read count at which a stray start is pulsed (-1 none)
    bit          start_in_done;
    int          exp_beats;
    logic [6:0]  last_a;
    logic [10:0] last_b;
  } vec_t;

  task automatic do_run(input vec_t v, input int idx);
    int t, first_rd, last_rd, gap, iss, dn0, dn1, done0_t, done1_t, hold_left;
    bit hold_fired, st_fired;
    logic busy_t1, cur_hold, cur_start;
    logic [17:0] last_addr;
    t = 0; first_rd = -1; last_rd = -1; gap = 0; iss = 0; dn0 = 0; dn1 = 0;
    done0_t = -1; done1_t = -1; hold_left = 0; hold_fired = 0; st_fired = 0;
    busy_t1 = 1'b0; last_addr = '0;
    clear_model(v.is_int4 ? 1 : 2);
    @(negedge clk);
    drive(1'b1, v.is_int4, 1'b0);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      t++;
      if (t == 1) busy_t1 = if0.busy;
      if (if0.rd_en) begin
        if (first_rd < 0) first_rd = t;
        last_rd = t; iss++; last_addr = {if0.addr_a, if0.addr_b};
      end else if (first_rd >= 0 && iss < v.exp_beats) begin
        gap++;
      end
      if (if0.done) begin dn0++; done0_t = t; end
      if (if1.done) begin dn1++; done1_t = t; end
      cur_start = 1'b0; cur_hold = 1'b0;
      if (hold_left > 0) begin cur_hold = 1'b1; hold_left--; end
      if (!hold_fired && v.hold_len > 0 && iss == v.hold_at) begin
        hold_fired = 1; cur_hold = 1'b1; hold_left = v.hold_len - 1;
      end
      if (!st_fired && v.start_at >= 0 && iss == v.start_at) begin
        st_fired = 1; cur_start = 1'b1;
      end
      if (v.start_in_done && if0.done) cur_start = 1'b1;
      drive(cur_start, cur_start ? !v.is_int4 : v.is_int4, cur_hold);
      if (done1_t >= 0 && t >= done1_t + 4) break;
    end
    drive(1'b0, 1'b0, 1'b0);
    chk($sformatf("v%0d busy_after_start", idx), busy_t1, 1);
    chk($sformatf("v%0d first_rd_cycle", idx), first_rd, 1);
    chk($sformatf("v%0d reads_issued", idx), iss, v.exp_beats);
    chk($sformatf("v%0d beats_lat1", idx), beat_n[0], v.exp_beats);
    chk($sformatf("v%0d beats_lat3", idx), beat_n[1], v.exp_beats);
    chk($sformatf("v%0d rd_low_gap", idx), gap, v.hold_len);
    chk($sformatf("v%0d rd_span", idx), last_rd - first_rd + 1, v.exp_beats + v.hold_len);
    chk($sformatf("v%0d last_addr", idx), last_addr, {v.last_a, v.last_b});
    chk($sformatf("v%0d done_count_lat1", idx), dn0, 1);
    chk($sformatf("v%0d done_count_lat3", idx), dn1, 1);
    chk($sformatf("v%0d done_after_last_rd_lat1", idx), done0_t - last_rd, 2);
    chk($sformatf("v%0d done_after_last_rd_lat3", idx), done1_t - last_rd, 4);
    chk($sformatf("v%0d run_time_lat1", idx), done0_t, v.exp_beats + v.hold_len + 2);
    chk($sformatf("v%0d busy_idle", idx), {if0.busy, if1.busy}, 2'b00);
  endtask

  vec_t vt [6];

  initial begin
    int iss, dn;
    vt[0] = '{0,  -1, 0,  -1, 0, 512, 7'd7, 11'd127};
    vt[1] = '{1,  -1, 0,  -1, 0, 256, 7'd6, 11'd126};
    vt[2] = '{0,  40, 5,  -1, 0, 512, 7'd7, 11'd127};
    vt[3] = '{1, 200, 3,  -1, 1, 256, 7'd6, 11'd126};
    vt[4] = '{0,  -1, 0, 100, 0, 512, 7'd7, 11'd127};
    vt[5] = '{0, 128, 1,  -1, 1, 512, 7'd7, 11'd127};

    drive(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_lat1", outs0(), '0);
    chk("reset_outputs_lat3", outs1(), '0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("idle_hold_no_read", {if0.rd_en, if0.busy, if1.rd_en, if1.busy}, 4'b0000);
    drive(1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;

    for (int i = 0; i < 6; i++) do_run(vt[i], i);

    // Reset in the middle of a run, then a clean run.
    clear_model(2);
    iss = 0; dn = 0;
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 1000 && iss < 300; c++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0);
      if (if0.rd_en) iss++;
      if (if0.done) dn++;
    end
    chk("abort_reached_beat300", iss, 300);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs_lat1", outs0(), '0);
    chk("abort_outputs_lat3", outs1(), '0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (if0.done || if1.done) dn++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (if0.done || if1.done) dn++;
    end
    chk("abort_no_done", dn, 0);
    chk("abort_idle", {if0.busy, if0.rd_en, if1.busy, if1.rd_en}, 4'b0000);
    do_run(vt[0], 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
